// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong game controller slice:
//   - pong_state_e : 2-bit game-state encoding (NEWGAME/PLAY/NEWBALL/OVER)
//   - TXT_*        : text-overlay region enable masks {score, logo, rule, over}
//   - default pause length and starting ball count
//   - bcd_inc2     : two-digit BCD increment with 99 -> 00 wrap
// -----------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } pong_state_e;

    // Region enable order is {score, logo, rule, over}
    localparam logic [3:0] TXT_NEWGAME = 4'b1110;
    localparam logic [3:0] TXT_PLAY    = 4'b1100;
    localparam logic [3:0] TXT_OVER    = 4'b1101;

    localparam int unsigned PAUSE_TICKS_DEF = 120;
    localparam int unsigned BALLS_INIT_DEF  = 3;

    // Increment a packed {tens, ones} BCD pair; 99 wraps to 00
    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0];
        hi = v[7:4];
        if (lo == 4'd9) begin
            lo = 4'd0;
            if (hi == 4'd9) begin
                hi = 4'd0;
            end else begin
                hi = hi + 4'd1;
            end
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/pong_score_cnt.sv
// -----------------------------------------------------------------------------
// pong_score_cnt
// Two-digit BCD score counter. clr has priority over inc.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset (clears both digits)
//   clr      in   clear score to 00
//   inc      in   add one to the score (99 wraps to 00)
//   dig0     out  ones digit, BCD
//   dig1     out  tens digit, BCD
// -----------------------------------------------------------------------------
module pong_score_cnt
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] dig0,
    output logic [3:0] dig1
);

    logic [7:0] r_score;

    // Score register: {tens, ones}
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_score <= 8'h00;
        end else if (clr) begin
            r_score <= 8'h00;
        end else if (inc) begin
            r_score <= bcd_inc2(r_score);
        end else begin
            r_score <= r_score;
        end
    end

    assign dig0 = r_score[3:0];
    assign dig1 = r_score[7:4];

endmodule

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
// Game-state sequencer for the pong display. Runs the NEWGAME/PLAY/NEWBALL/OVER
// flow, owns the balls-remaining count and the BCD score, and times the
// new-ball and game-over pauses from the frame tick.
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   refr_tick  in   one-cycle pulse per frame
//   btn[1:0]   in   debounced paddle buttons (level)
//   hit        in   one-cycle pulse: ball returned by paddle
//   miss       in   one-cycle pulse: ball passed paddle
//   ball[1:0]  out  balls remaining
//   dig0[3:0]  out  score ones digit, BCD
//   dig1[3:0]  out  score tens digit, BCD
//   text_en    out  region enables {score, logo, rule, over}
//   gra_still  out  1 = graphics frozen, ball parked
//   game_over  out  1 while in OVER
// -----------------------------------------------------------------------------
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned BALLS_INIT  = BALLS_INIT_DEF,
    parameter int unsigned PAUSE_TICKS = PAUSE_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refr_tick,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic [1:0] ball,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] text_en,
    output logic       gra_still,
    output logic       game_over
);

    localparam logic [1:0] LP_BALLS = BALLS_INIT[1:0];
    localparam logic [6:0] LP_PAUSE = PAUSE_TICKS[6:0];

    pong_state_e r_state;
    pong_state_e w_state_nxt;
    logic [1:0]  r_ball;
    logic [1:0]  w_ball_nxt;
    logic [6:0]  r_timer;
    logic        r_prev_any;
    logic        w_btn_press;
    logic        w_timer_done;
    logic        w_timer_load;
    logic        w_score_clr;
    logic        w_score_inc;
    logic [3:0]  r_text_en;
    logic        r_gra_still;
    logic        r_game_over;
    logic [3:0]  w_text_en_nxt;
    logic        w_gra_still_nxt;
    logic        w_game_over_nxt;

    // A held button must yield a single press, so only the rising edge of
    // "any button down" counts
    assign w_btn_press  = (|btn) & ~r_prev_any;
    assign w_timer_done = (r_timer == 7'd0);

    // Button-level history for edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev_any <= 1'b0;
        end else begin
            r_prev_any <= |btn;
        end
    end

    // Pause timer: load beats the per-frame decrement
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_timer <= 7'd0;
        end else if (w_timer_load) begin
            r_timer <= LP_PAUSE;
        end else if (refr_tick && !w_timer_done) begin
            r_timer <= r_timer - 7'd1;
        end else begin
            r_timer <= r_timer;
        end
    end

    // Next-state, ball-count and score-control decode
    always_comb begin
        w_state_nxt  = r_state;
        w_ball_nxt   = r_ball;
        w_timer_load = 1'b0;
        w_score_clr  = 1'b0;
        w_score_inc  = 1'b0;
        case (r_state)
            ST_NEWGAME: begin
                if (w_btn_press) begin
                    w_score_clr = 1'b1;
                    w_state_nxt = ST_PLAY;
                    if (r_ball != 2'd0) begin
                        w_ball_nxt = r_ball - 2'd1;
                    end else begin
                        w_ball_nxt = r_ball;
                    end
                end else begin
                    w_state_nxt = ST_NEWGAME;
                end
            end
            ST_PLAY: begin
                // miss outranks a simultaneous hit; that hit is dropped
                if (miss) begin
                    w_timer_load = 1'b1;
                    if (r_ball == 2'd0) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_ball_nxt  = r_ball - 2'd1;
                        w_state_nxt = ST_NEWBALL;
                    end
                end else if (hit) begin
                    w_score_inc = 1'b1;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_NEWBALL: begin
                // Presses during the pause are simply lost, not queued
                if (w_timer_done && w_btn_press) begin
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_state_nxt = ST_NEWBALL;
                end
            end
            ST_OVER: begin
                // Score is left untouched so it stays on screen until restart
                if (w_timer_done) begin
                    w_ball_nxt  = LP_BALLS;
                    w_state_nxt = ST_NEWGAME;
                end else begin
                    w_state_nxt = ST_OVER;
                end
            end
            default: begin
                w_state_nxt = ST_NEWGAME;
            end
        endcase
    end

    // Moore output decode from the next state so outputs land with the state
    always_comb begin
        w_text_en_nxt   = TXT_NEWGAME;
        w_gra_still_nxt = 1'b1;
        w_game_over_nxt = 1'b0;
        case (w_state_nxt)
            ST_NEWGAME: begin
                w_text_en_nxt   = TXT_NEWGAME;
                w_gra_still_nxt = 1'b1;
                w_game_over_nxt = 1'b0;
            end
            ST_PLAY: begin
                w_text_en_nxt   = TXT_PLAY;
                w_gra_still_nxt = 1'b0;
                w_game_over_nxt = 1'b0;
            end
            ST_NEWBALL: begin
                w_text_en_nxt   = TXT_PLAY;
                w_gra_still_nxt = 1'b1;
                w_game_over_nxt = 1'b0;
            end
            ST_OVER: begin
                w_text_en_nxt   = TXT_OVER;
                w_gra_still_nxt = 1'b1;
                w_game_over_nxt = 1'b1;
            end
            default: begin
                w_text_en_nxt   = TXT_NEWGAME;
                w_gra_still_nxt = 1'b1;
                w_game_over_nxt = 1'b0;
            end
        endcase
    end

    // State, ball count and registered overlay/graphics controls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_NEWGAME;
            r_ball      <= LP_BALLS;
            r_text_en   <= TXT_NEWGAME;
            r_gra_still <= 1'b1;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ball      <= w_ball_nxt;
            r_text_en   <= w_text_en_nxt;
            r_gra_still <= w_gra_still_nxt;
            r_game_over <= w_game_over_nxt;
        end
    end

    pong_score_cnt u_score (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_score_clr),
        .inc     (w_score_inc),
        .dig0    (dig0),
        .dig1    (dig1)
    );

    assign ball      = r_ball;
    assign text_en   = r_text_en;
    assign gra_still = r_gra_still;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
// Directed bench for pong_game_ctrl. The observed vector packs
// {ball, dig1, dig0, text_en, gra_still, game_over} so each step of the game
// flow can be compared against a hand-computed expectation.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

    logic       clk;
    logic       reset_n;
    logic       refr_tick;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic [1:0] ball;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] text_en;
    logic       gra_still;
    logic       game_over;

    int n_checks;
    int n_errors;

    logic [15:0] obs;
    logic [15:0] exp_v;

    assign obs = {ball, dig1, dig0, text_en, gra_still, game_over};

    pong_game_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .refr_tick (refr_tick),
        .btn       (btn),
        .hit       (hit),
        .miss      (miss),
        .ball      (ball),
        .dig0      (dig0),
        .dig1      (dig1),
        .text_en   (text_en),
        .gra_still (gra_still),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges; inputs change and outputs are sampled 1 ns later
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_hits(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1;
            step(1);
            hit = 1'b0;
        end
    endtask

    task automatic do_miss();
        miss = 1'b1;
        step(1);
        miss = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            refr_tick = 1'b1;
            step(1);
            refr_tick = 1'b0;
            step(1);
        end
    endtask

    task automatic press();
        btn = 2'b01;
        step(1);
        btn = 2'b00;
        step(1);
    endtask

    // Wait out a full NEWBALL pause and relaunch
    task automatic pass_pause();
        do_ticks(120);
        step(1);
        press();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        exp_v = {2'd3, 4'd0, 4'd0, 4'b1110, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        // hit/miss outside PLAY must not change anything
        do_hits(1);
        do_miss();
        step(2);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL newgame_ignore_hit_miss: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_start();
        btn = 2'b01;
        step(1);
        exp_v = {2'd2, 4'd0, 4'd0, 4'b1100, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL start_play: got %h expected %h", obs, exp_v);
        end
        step(9);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL start_held: got %h expected %h", obs, exp_v);
        end
        btn = 2'b11;
        step(2);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL start_second_btn_no_release: got %h expected %h", obs, exp_v);
        end
        btn = 2'b00;
        step(1);
    endtask

    task automatic test_score();
        do_hits(9);
        exp_v = {2'd2, 4'd0, 4'd9, 4'b1100, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL score_09: got %h expected %h", obs, exp_v);
        end
        do_hits(1);
        exp_v = {2'd2, 4'd1, 4'd0, 4'b1100, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL score_10: got %h expected %h", obs, exp_v);
        end
        do_hits(2);
        exp_v = {2'd2, 4'd1, 4'd2, 4'b1100, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL score_12: got %h expected %h", obs, exp_v);
        end
        do_hits(87);
        exp_v = {2'd2, 4'd9, 4'd9, 4'b1100, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL score_99: got %h expected %h", obs, exp_v);
        end
        do_hits(1);
        exp_v = {2'd2, 4'd0, 4'd0, 4'b1100, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL score_wrap_00: got %h expected %h", obs, exp_v);
        end
        do_hits(5);
    endtask

    task automatic test_hit_miss_same_cycle();
        hit  = 1'b1;
        miss = 1'b1;
        step(1);
        hit  = 1'b0;
        miss = 1'b0;
        exp_v = {2'd1, 4'd0, 4'd5, 4'b1100, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL hit_miss_newball: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_newball_pause();
        do_ticks(49);
        // Press coinciding with the 50th tick
        refr_tick = 1'b1;
        btn       = 2'b01;
        step(1);
        refr_tick = 1'b0;
        btn       = 2'b00;
        step(1);
        exp_v = {2'd1, 4'd0, 4'd5, 4'b1100, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL newball_press_tick50: got %h expected %h", obs, exp_v);
        end
        do_ticks(69);
        press();
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL newball_press_tick119: got %h expected %h", obs, exp_v);
        end
        do_ticks(1);
        step(3);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL newball_no_queue: got %h expected %h", obs, exp_v);
        end
        btn = 2'b01;
        step(1);
        btn = 2'b00;
        exp_v = {2'd1, 4'd0, 4'd5, 4'b1100, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL newball_to_play: got %h expected %h", obs, exp_v);
        end
        step(1);
    endtask

    task automatic test_last_ball_and_over();
        do_miss();
        exp_v = {2'd0, 4'd0, 4'd5, 4'b1100, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL miss_to_ball0: got %h expected %h", obs, exp_v);
        end
        pass_pause();
        exp_v = {2'd0, 4'd0, 4'd5, 4'b1100, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL play_ball0: got %h expected %h", obs, exp_v);
        end
        do_hits(3);
        do_miss();
        exp_v = {2'd0, 4'd0, 4'd8, 4'b1101, 1'b1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL over_entry: got %h expected %h", obs, exp_v);
        end
        do_hits(1);
        do_ticks(119);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL over_hold_119: got %h expected %h", obs, exp_v);
        end
        refr_tick = 1'b1;
        step(1);
        refr_tick = 1'b0;
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL over_tick120_edge: got %h expected %h", obs, exp_v);
        end
        step(1);
        exp_v = {2'd3, 4'd0, 4'd8, 4'b1110, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL over_to_newgame: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_in_over();
        press();
        exp_v = {2'd2, 4'd0, 4'd0, 4'b1100, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL restart_clears_score: got %h expected %h", obs, exp_v);
        end
        do_hits(2);
        do_miss();
        pass_pause();
        do_miss();
        pass_pause();
        do_miss();
        exp_v = {2'd0, 4'd0, 4'd2, 4'b1101, 1'b1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL second_game_over: got %h expected %h", obs, exp_v);
        end
        do_ticks(30);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        exp_v = {2'd3, 4'd0, 4'd0, 4'b1110, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL reset_mid_over: got %h expected %h", obs, exp_v);
        end
        step(2);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL reset_mid_over_stays: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        refr_tick = 1'b0;
        btn       = 2'b00;
        hit       = 1'b0;
        miss      = 1'b0;
        #1;
        test_reset();
        test_start();
        test_score();
        test_hit_miss_same_cycle();
        test_newball_pause();
        test_last_ball_and_over();
        test_reset_in_over();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
